rr_arb_2to1: RTL and testbench



---
 rtl/rr_arb_2to1_pkg.sv | 11 +
 rtl/rr_arb_grant.sv | 23 ++
 rtl/rr_arb_2to1.sv | 75 +++++++
 tb/tb_rr_arb_2to1.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/rr_arb_2to1_pkg.sv
// Shared constants for the two-requester round-robin arbiter.
package rr_arb_2to1_pkg;

  // Source identifiers, also the encoding of the downstream mux select.
  localparam logic SRC_IN0 = 1'b0;
  localparam logic SRC_IN1 = 1'b1;

  // Width of the burst counter; MAX_BURST must fit (1..15).
  localparam int unsigned BURST_W = 4;

endpackage

// File: rtl/rr_arb_grant.sv
// Pure combinational grant decision for the 2:1 round-robin arbiter.
module rr_arb_grant
  import rr_arb_2to1_pkg::*;
(
  input  logic in0_valid,
  input  logic in1_valid,
  input  logic owner,
  input  logic burst_max,  // owner must yield on the next tie
  output logic grant
);

  // A lone requester always wins; a tie goes to owner unless it must yield.
  always_comb begin
    grant = owner;
    unique case ({in1_valid, in0_valid})
      2'b01:   grant = SRC_IN0;
      2'b10:   grant = SRC_IN1;
      2'b11:   grant = burst_max ? ~owner : owner;
      default: grant = owner;
    endcase
  end

endmodule

// File: rtl/rr_arb_2to1.sv
// Two-requester round-robin arbiter with valid/ready handshakes and a
// registered output stage feeding the downstream 2:1 select mux.
module rr_arb_2to1
  import rr_arb_2to1_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  input  logic             out_ready
);

  localparam logic [BURST_W-1:0] MAX_CNT = BURST_W'(MAX_BURST);

  logic               owner;
  logic [BURST_W-1:0] burst_cnt;
  logic               grant;
  logic               load;
  logic               yield;

  // burst_cnt is 0 only between reset and the first load: nobody holds a
  // burst yet, so a tie goes to the non-owner. With owner=1 out of reset this
  // lets in0 win the first tie.
  assign yield = (burst_cnt == MAX_CNT) || (burst_cnt == '0);

  rr_arb_grant u_grant (
    .in0_valid (in0_valid),
    .in1_valid (in1_valid),
    .owner     (owner),
    .burst_max (yield),
    .grant     (grant)
  );

  // No handshake may complete while rst is high.
  assign load      = !rst && (!out_valid || out_ready) && (in0_valid || in1_valid);
  assign in0_ready = load && (grant == SRC_IN0);
  assign in1_ready = load && (grant == SRC_IN1);

  // Output register plus round-robin owner/burst bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= SRC_IN0;
      owner     <= SRC_IN1;
      burst_cnt <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= (grant == SRC_IN1) ? in1_data : in0_data;
      out_sel   <= grant;
      if (grant == owner) begin
        if (burst_cnt < MAX_CNT) begin
          burst_cnt <= burst_cnt + 1'b1;
        end
      end else begin
        owner     <= grant;
        burst_cnt <= BURST_W'(1);
      end
    end else if (out_valid && out_ready) begin
      // Drain with nothing to replace it; data and select hold.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb_2to1.sv
// Directed self-checking bench for rr_arb_2to1 (WIDTH=8, MAX_BURST=2).
module tb_rr_arb_2to1;

  logic       clk = 1'b0;
  logic       rst;
  logic       in0_valid, in1_valid, out_ready;
  logic [7:0] in0_data, in1_data;
  logic       in0_ready, in1_ready, out_valid, out_sel;
  logic [7:0] out_data;

  int checks = 0;
  int errors = 0;

  logic       exp_sel  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [7:0] exp_data [6] = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA2, 8'hA3};
  logic       post_sel [3] = '{1'b1, 1'b1, 1'b0};
  logic [7:0] post_data[3] = '{8'hB2, 8'hB3, 8'hA4};
  logic [7:0] single   [3] = '{8'h11, 8'h22, 8'h33};

  always #5 clk = ~clk;

  rr_arb_2to1 #(
    .WIDTH     (8),
    .MAX_BURST (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in0_valid = 1'b1;
    in0_data  = 8'h00;
    in1_valid = 1'b0;
    in1_data  = 8'h00;
    out_ready = 1'b1;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sel", out_sel, 0);
    check("rst_in0_ready", in0_ready, 0);
    check("rst_in1_ready", in1_ready, 0);
    tick();
    check("rst_hold_valid", out_valid, 0);
    rst = 1'b0;

    // Contention from reset: first tie to in0, then bursts of two.
    in0_valid = 1'b1; in0_data = 8'hA0;
    in1_valid = 1'b1; in1_data = 8'hB0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("cont_in0_ready_%0d", i), in0_ready, exp_sel[i] == 1'b0);
      check($sformatf("cont_in1_ready_%0d", i), in1_ready, exp_sel[i] == 1'b1);
      tick();
      check($sformatf("cont_valid_%0d", i), out_valid, 1);
      check($sformatf("cont_sel_%0d", i), out_sel, exp_sel[i]);
      check($sformatf("cont_data_%0d", i), out_data, exp_data[i]);
      if (exp_sel[i]) in1_data = in1_data + 8'h01;
      else            in0_data = in0_data + 8'h01;
    end

    // Backpressure for three cycles: everything frozen.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_in0_ready_%0d", i), in0_ready, 0);
      check($sformatf("bp_in1_ready_%0d", i), in1_ready, 0);
      tick();
      check($sformatf("bp_valid_%0d", i), out_valid, 1);
      check($sformatf("bp_data_%0d", i), out_data, 8'hA3);
      check($sformatf("bp_sel_%0d", i), out_sel, 0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("post_in1_ready_%0d", i), in1_ready, post_sel[i] == 1'b1);
      tick();
      check($sformatf("post_sel_%0d", i), out_sel, post_sel[i]);
      check($sformatf("post_data_%0d", i), out_data, post_data[i]);
      if (post_sel[i]) in1_data = in1_data + 8'h01;
      else             in0_data = in0_data + 8'h01;
    end

    // Asynchronous reset mid-stream with out_valid=1 and out_sel=0 held.
    check("pre_rst_valid", out_valid, 1);
    in1_valid = 1'b1; in1_data = 8'hB9;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sel", out_sel, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_in0_ready", in0_ready, 0);
    check("mid_rst_in1_ready", in1_ready, 0);
    tick();
    check("mid_rst_edge_valid", out_valid, 0);
    rst = 1'b0;
    in0_data = 8'hC0; in1_data = 8'hD0;
    #1;
    check("after_rst_in0_ready", in0_ready, 1);
    check("after_rst_in1_ready", in1_ready, 0);
    tick();
    check("after_rst_sel", out_sel, 0);
    check("after_rst_data", out_data, 8'hC0);

    // Single source on in0.
    in1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in0_data = single[i];
      #1;
      check($sformatf("single_in0_ready_%0d", i), in0_ready, 1);
      check($sformatf("single_in1_ready_%0d", i), in1_ready, 0);
      tick();
      check($sformatf("single_data_%0d", i), out_data, single[i]);
      check($sformatf("single_sel_%0d", i), out_sel, 0);
    end

    // Drain and load in the same cycle: no bubble.
    in0_valid = 1'b0;
    in1_valid = 1'b1; in1_data = 8'h5C;
    #1;
    check("b2b_in1_ready", in1_ready, 1);
    tick();
    check("b2b_valid", out_valid, 1);
    check("b2b_data", out_data, 8'h5C);
    check("b2b_sel", out_sel, 1);

    // Drain to empty: valid falls, data/sel hold.
    in1_valid = 1'b0;
    #1;
    check("drain_in0_ready", in0_ready, 0);
    check("drain_in1_ready", in1_ready, 0);
    tick();
    check("drain_valid", out_valid, 0);
    check("drain_data", out_data, 8'h5C);
    check("drain_sel", out_sel, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
